mainfsm_hs: RTL and testbench

//  Parametrised successor of the multicycle ARM main control FSM. Moore-style decoder driving the datapath muxes and enables.

---
 rtl/mainfsm_hs_pkg.sv | 58 +++++
 rtl/mainfsm_hs_if.sv | 45 ++++
 rtl/mainfsm_hs_timeout_cnt.sv | 36 +++
 rtl/mainfsm_hs.sv | 162 ++++++++++++++++
 tb/tb_mainfsm_hs.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mainfsm_hs_pkg.sv
// Shared definitions for the handshaked multicycle main control FSM:
// state encoding, control-word bit positions and datapath mux encodings.
package mainfsm_hs_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_MEMADR     = 4'd2,
    S_MEMRD      = 4'd3,
    S_MEMWB      = 4'd4,
    S_MEMWR      = 4'd5,
    S_EXECUTER   = 4'd6,
    S_EXECUTEI   = 4'd7,
    S_ALUWB      = 4'd8,
    S_BRANCH     = 4'd9,
    S_FAULT      = 4'd10,
    S_EXECUTEF   = 4'd11,
    S_FPUWB      = 4'd12,
    S_ALU64WB_LO = 4'd13,
    S_FPUWAIT    = 4'd14,
    S_ALU64WB_HI = 4'd15
  } state_t;

  // Control-word bit positions (two-bit fields occupy [pos +: 2]).
  localparam int CW_IRWRITE  = 0;
  localparam int CW_ADRSRC   = 1;
  localparam int CW_NEXTPC   = 2;
  localparam int CW_BRANCH   = 3;
  localparam int CW_MEMW     = 4;
  localparam int CW_REGW     = 5;
  localparam int CW_ALUOP    = 6;
  localparam int CW_RS       = 7;
  localparam int CW_SA       = 9;
  localparam int CW_SB       = 11;
  localparam int CW_SRC64    = 13;
  localparam int CW_FPUW     = 14;
  localparam int CW_FPUSTART = 15;
  localparam int CW_MEMREQ   = 16;
  localparam int CW_FAULT    = 17;
  localparam int CW_W        = 18;

  // ResultSrc encodings.
  localparam logic [1:0] RS_ALUOUT    = 2'b00;
  localparam logic [1:0] RS_DATA      = 2'b01;
  localparam logic [1:0] RS_ALURESULT = 2'b10;

  // ALUSrcA encodings.
  localparam logic [1:0] SA_RN = 2'b00;
  localparam logic [1:0] SA_PC = 2'b01;

  // ALUSrcB encodings.
  localparam logic [1:0] SB_RM   = 2'b00;
  localparam logic [1:0] SB_IMM  = 2'b01;
  localparam logic [1:0] SB_FOUR = 2'b10;

endpackage

// File: rtl/mainfsm_hs_if.sv
// Decoder/datapath side of the main FSM: instruction class inputs,
// handshakes and all datapath control outputs.
interface mainfsm_hs_if;
  import mainfsm_hs_pkg::*;

  logic [1:0]         Op;
  logic [5:0]         Funct;
  logic               Flag_64b;
  logic               MemReady;
  logic               FpuDone;

  logic               IRWrite;
  logic               AdrSrc;
  logic               NextPC;
  logic               Branch;
  logic               MemW;
  logic               RegW;
  logic               ALUOp;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic               Src_64b;
  logic               FpuW;
  logic               FpuStart;
  logic               MemReq;
  logic               Fault;
  logic [STATE_W-1:0] StateOut;

  // Controller side.
  modport master (
    input  Op, Funct, Flag_64b, MemReady, FpuDone,
    output IRWrite, AdrSrc, NextPC, Branch, MemW, RegW, ALUOp,
           ResultSrc, ALUSrcA, ALUSrcB, Src_64b, FpuW, FpuStart,
           MemReq, Fault, StateOut
  );

  // Datapath / decoder side.
  modport slave (
    output Op, Funct, Flag_64b, MemReady, FpuDone,
    input  IRWrite, AdrSrc, NextPC, Branch, MemW, RegW, ALUOp,
           ResultSrc, ALUSrcA, ALUSrcB, Src_64b, FpuW, FpuStart,
           MemReq, Fault, StateOut
  );

endinterface

// File: rtl/mainfsm_hs_timeout_cnt.sv
// FPU wait-time counter: cleared on request, counts while enabled,
// saturates at all-ones and flags the last permitted wait cycle.
module mainfsm_timeout_cnt #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [CNT_W-1:0] cnt;

  // Saturating wait counter; clear has priority over counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

  // A zero timeout disables expiry entirely.
  assign expired = (TIMEOUT != 0) && (cnt == CNT_LAST);

endmodule

// File: rtl/mainfsm_hs.sv
// Multicycle main control FSM with memory ready handshake, FPU start/done
// handshake with timeout, two-cycle 64-bit writeback and sticky FAULT.
// Moore-style: controls decode from state; only IRWrite/NextPC in FETCH
// are qualified by MemReady so the fetch commits exactly once.
module mainfsm_hs
  import mainfsm_hs_pkg::*;
#(
  parameter int MEM_HS      = 1,
  parameter int FPU_EN      = 1,
  parameter int FPU_TIMEOUT = 15,
  parameter int CNT_W       = 4,
  parameter int WIDE_WB     = 1
) (
  input  logic         clk,
  input  logic         reset,
  mainfsm_hs_if.master bus
);

  state_t            state;
  state_t            state_next;
  logic              mem_rdy;
  logic              wide_sel;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_expired;
  logic [CW_W-1:0]   ctrl;
  logic              unused_funct;

  assign mem_rdy      = (MEM_HS != 0) ? bus.MemReady : 1'b1;
  assign wide_sel     = (WIDE_WB != 0) && bus.Flag_64b;
  assign cnt_clr      = (state == S_EXECUTEF);
  assign cnt_en       = (state == S_FPUWAIT) && !bus.FpuDone;
  assign unused_funct = ^bus.Funct[4:1];

  mainfsm_timeout_cnt #(
    .CNT_W   (CNT_W),
    .TIMEOUT (FPU_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (cnt_expired)
  );

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:      state_next = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          2'b00:   state_next = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_next = S_MEMADR;
          2'b10:   state_next = S_BRANCH;
          2'b11:   state_next = (FPU_EN != 0) ? S_EXECUTEF : S_FAULT;
          default: state_next = S_FAULT;
        endcase
      end
      S_MEMADR:     state_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:      state_next = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:      state_next = S_FETCH;
      S_MEMWR:      state_next = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXECUTER,
      S_EXECUTEI:   state_next = wide_sel ? S_ALU64WB_LO : S_ALUWB;
      S_ALUWB:      state_next = S_FETCH;
      S_ALU64WB_LO: state_next = S_ALU64WB_HI;
      S_ALU64WB_HI: state_next = S_FETCH;
      S_BRANCH:     state_next = S_FETCH;
      S_EXECUTEF:   state_next = S_FPUWAIT;
      // FpuDone in the expiry cycle still completes the operation.
      S_FPUWAIT:    state_next = bus.FpuDone ? S_FPUWB :
                                 (cnt_expired ? S_FAULT : S_FPUWAIT);
      S_FPUWB:      state_next = S_FETCH;
      S_FAULT:      state_next = S_FAULT;
      default:      state_next = S_FAULT;
    endcase
  end

  // Control-word decode per state.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl[CW_MEMREQ]  = 1'b1;
        ctrl[CW_IRWRITE] = mem_rdy;
        ctrl[CW_NEXTPC]  = mem_rdy;
        ctrl[CW_RS +: 2] = RS_ALURESULT;
        ctrl[CW_SA +: 2] = SA_PC;
        ctrl[CW_SB +: 2] = SB_FOUR;
      end
      S_DECODE: begin
        ctrl[CW_RS +: 2] = RS_ALURESULT;
        ctrl[CW_SA +: 2] = SA_PC;
        ctrl[CW_SB +: 2] = SB_FOUR;
      end
      S_MEMADR:   ctrl[CW_SB +: 2] = SB_IMM;
      S_MEMRD: begin
        ctrl[CW_MEMREQ] = 1'b1;
        ctrl[CW_ADRSRC] = 1'b1;
      end
      S_MEMWB: begin
        ctrl[CW_REGW]    = 1'b1;
        ctrl[CW_RS +: 2] = RS_DATA;
      end
      S_MEMWR: begin
        ctrl[CW_MEMREQ] = 1'b1;
        ctrl[CW_ADRSRC] = 1'b1;
        ctrl[CW_MEMW]   = 1'b1;
      end
      S_EXECUTER: ctrl[CW_ALUOP] = 1'b1;
      S_EXECUTEI: begin
        ctrl[CW_ALUOP]   = 1'b1;
        ctrl[CW_SB +: 2] = SB_IMM;
      end
      S_ALUWB:      ctrl[CW_REGW] = 1'b1;
      S_ALU64WB_LO: ctrl[CW_REGW] = 1'b1;
      S_ALU64WB_HI: begin
        ctrl[CW_REGW]  = 1'b1;
        ctrl[CW_SRC64] = 1'b1;
      end
      S_BRANCH: begin
        ctrl[CW_BRANCH]  = 1'b1;
        ctrl[CW_RS +: 2] = RS_ALURESULT;
        ctrl[CW_SB +: 2] = SB_IMM;
      end
      S_EXECUTEF: ctrl[CW_FPUSTART] = 1'b1;
      S_FPUWAIT:  ctrl = '0;
      S_FPUWB:    ctrl[CW_FPUW]  = 1'b1;
      S_FAULT:    ctrl[CW_FAULT] = 1'b1;
      default:    ctrl[CW_FAULT] = 1'b1;
    endcase
  end

  // Reset abandons a pending access and suppresses the fetch commit.
  assign bus.MemReq    = ctrl[CW_MEMREQ]  & reset;
  assign bus.IRWrite   = ctrl[CW_IRWRITE] & reset;
  assign bus.NextPC    = ctrl[CW_NEXTPC]  & reset;
  assign bus.AdrSrc    = ctrl[CW_ADRSRC];
  assign bus.Branch    = ctrl[CW_BRANCH];
  assign bus.MemW      = ctrl[CW_MEMW];
  assign bus.RegW      = ctrl[CW_REGW];
  assign bus.ALUOp     = ctrl[CW_ALUOP];
  assign bus.ResultSrc = ctrl[CW_RS +: 2];
  assign bus.ALUSrcA   = ctrl[CW_SA +: 2];
  assign bus.ALUSrcB   = ctrl[CW_SB +: 2];
  assign bus.Src_64b   = ctrl[CW_SRC64];
  assign bus.FpuW      = ctrl[CW_FPUW];
  assign bus.FpuStart  = ctrl[CW_FPUSTART];
  assign bus.Fault     = ctrl[CW_FAULT];
  assign bus.StateOut  = state;

endmodule

// File: tb/tb_mainfsm_hs.sv
// Directed scoreboard bench for mainfsm_hs: each stimulus cycle pushes the
// expected state and control outputs; a negedge monitor pops and compares.
module tb_mainfsm_hs;

  localparam logic [3:0] FETCH = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3;
  localparam logic [3:0] MEMWB = 4'd4,  MEMWR = 4'd5,   EXR = 4'd6,     EXI = 4'd7;
  localparam logic [3:0] ALUWB = 4'd8,  BRANCH = 4'd9,  FAULT = 4'd10,  EXF = 4'd11;
  localparam logic [3:0] FPUWB = 4'd12, WBLO = 4'd13,   FPUWAIT = 4'd14, WBHI = 4'd15;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic       branch;
    logic       mem_w;
    logic       reg_w;
    logic       alu_op;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       src64;
    logic       fpu_w;
    logic       fpu_start;
    logic       fault;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  obs_t exp_q[$];
  string name_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mainfsm_hs_if bus();

  mainfsm_hs #(
    .MEM_HS(1), .FPU_EN(1), .FPU_TIMEOUT(15), .CNT_W(4), .WIDE_WB(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected outputs for a state, straight from the state/output table.
  function automatic obs_t spec_out(input logic [3:0] st, input logic mr, input logic rn);
    obs_t o;
    o = '0;
    o.st = st;
    case (st)
      FETCH:   begin o.mem_req = rn; o.ir_write = mr & rn; o.next_pc = mr & rn;
                     o.rs = 2'b10; o.sa = 2'b01; o.sb = 2'b10; end
      DECODE:  begin o.rs = 2'b10; o.sa = 2'b01; o.sb = 2'b10; end
      MEMADR:  o.sb = 2'b01;
      MEMRD:   begin o.mem_req = 1'b1; o.adr_src = 1'b1; end
      MEMWB:   begin o.reg_w = 1'b1; o.rs = 2'b01; end
      MEMWR:   begin o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_w = 1'b1; end
      EXR:     o.alu_op = 1'b1;
      EXI:     begin o.alu_op = 1'b1; o.sb = 2'b01; end
      ALUWB:   o.reg_w = 1'b1;
      BRANCH:  begin o.branch = 1'b1; o.rs = 2'b10; o.sb = 2'b01; end
      FAULT:   o.fault = 1'b1;
      EXF:     o.fpu_start = 1'b1;
      FPUWB:   o.fpu_w = 1'b1;
      WBLO:    o.reg_w = 1'b1;
      FPUWAIT: o.fault = 1'b0;
      WBHI:    begin o.reg_w = 1'b1; o.src64 = 1'b1; end
      default: o.fault = 1'b0;
    endcase
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.st        = bus.StateOut;
    a.mem_req   = bus.MemReq;
    a.ir_write  = bus.IRWrite;
    a.next_pc   = bus.NextPC;
    a.adr_src   = bus.AdrSrc;
    a.branch    = bus.Branch;
    a.mem_w     = bus.MemW;
    a.reg_w     = bus.RegW;
    a.alu_op    = bus.ALUOp;
    a.rs        = bus.ResultSrc;
    a.sa        = bus.ALUSrcA;
    a.sb        = bus.ALUSrcB;
    a.src64     = bus.Src_64b;
    a.fpu_w     = bus.FpuW;
    a.fpu_start = bus.FpuStart;
    a.fault     = bus.Fault;
    return a;
  endfunction

  // Monitor: compare DUT outputs against the oldest pending expectation.
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = sample();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: state %0d ctrl %h, expected state %0d ctrl %h",
                 n, a.st, a, e.st, e);
      end
    end
  end

  // Apply one cycle of inputs and queue the expected response.
  task automatic cyc(input string n, input logic [1:0] op, input logic [5:0] fn,
                     input logic f64, input logic mr, input logic fd,
                     input logic rn, input logic [3:0] st);
    @(posedge clk);
    #1;
    reset        = rn;
    bus.Op       = op;
    bus.Funct    = fn;
    bus.Flag_64b = f64;
    bus.MemReady = mr;
    bus.FpuDone  = fd;
    exp_q.push_back(spec_out(st, mr, rn));
    name_q.push_back(n);
  endtask

  initial begin
    reset        = 1'b0;
    bus.Op       = 2'b00;
    bus.Funct    = 6'h00;
    bus.Flag_64b = 1'b0;
    bus.MemReady = 1'b0;
    bus.FpuDone  = 1'b0;

    // Reset: FETCH, MemReq and fetch commit suppressed even with MemReady high.
    cyc("reset_gate",  2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, FETCH);
    cyc("reset_hold",  2'b00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, FETCH);
    cyc("fetch_stall", 2'b00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, FETCH);
    cyc("fetch_stall", 2'b00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, FETCH);

    // ADD register.
    cyc("add_fetch",  2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, FETCH);
    cyc("add_decode", 2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, DECODE);
    cyc("add_exec",   2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, EXR);
    cyc("add_wb",     2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, ALUWB);

    // ADD immediate.
    cyc("addi_fetch",  2'b00, 6'h20, 1'b0, 1'b1, 1'b0, 1'b1, FETCH);
    cyc("addi_decode", 2'b00, 6'h20, 1'b0, 1'b1, 1'b0, 1'b1, DECODE);
    cyc("addi_exec",   2'b00, 6'h20, 1'b0, 1'b1, 1'b0, 1'b1, EXI);
    cyc("addi_wb",     2'b00, 6'h20, 1'b0, 1'b1, 1'b0, 1'b1, ALUWB);

    // UMULL: two-cycle wide writeback.
    cyc("umull_fetch",  2'b00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b1, FETCH);
    cyc("umull_decode", 2'b00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b1, DECODE);
    cyc("umull_exec",   2'b00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b1, EXR);
    cyc("umull_wb_lo",  2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, WBLO);
    cyc("umull_wb_hi",  2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, WBHI);

    // LDR with three wait cycles in MEMRD.
    cyc("ldr_fetch",  2'b01, 6'h01, 1'b0, 1'b1, 1'b0, 1'b1, FETCH);
    cyc("ldr_decode", 2'b01, 6'h01, 1'b0, 1'b1, 1'b0, 1'b1, DECODE);
    cyc("ldr_adr",    2'b01, 6'h01, 1'b0, 1'b1, 1'b0, 1'b1, MEMADR);
    for (int i = 0; i < 3; i++)
      cyc("ldr_rd_wait", 2'b01, 6'h01, 1'b0, 1'b0, 1'b0, 1'b1, MEMRD);
    cyc("ldr_rd_done", 2'b01, 6'h01, 1'b0, 1'b1, 1'b0, 1'b1, MEMRD);
    cyc("ldr_wb",      2'b01, 6'h01, 1'b0, 1'b1, 1'b0, 1'b1, MEMWB);

    // Branch.
    cyc("b_fetch",  2'b10, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, FETCH);
    cyc("b_decode", 2'b10, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, DECODE);
    cyc("b_branch", 2'b10, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, BRANCH);

    // FP op, FpuDone on the 5th wait cycle.
    cyc("fp5_fetch",  2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, FETCH);
    cyc("fp5_decode", 2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, DECODE);
    cyc("fp5_start",  2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, EXF);
    for (int i = 0; i < 4; i++)
      cyc("fp5_wait", 2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, FPUWAIT);
    cyc("fp5_done",   2'b11, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, FPUWAIT);
    cyc("fp5_wb",     2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, FPUWB);

    // FP op, FpuDone exactly in the expiry cycle wins.
    cyc("fp15_fetch",  2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, FETCH);
    cyc("fp15_decode", 2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, DECODE);
    cyc("fp15_start",  2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, EXF);
    for (int i = 0; i < 14; i++)
      cyc("fp15_wait", 2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, FPUWAIT);
    cyc("fp15_done",   2'b11, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, FPUWAIT);
    cyc("fp15_wb",     2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, FPUWB);

    // STR interrupted by reset while waiting for memory.
    cyc("str_fetch",   2'b01, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, FETCH);
    cyc("str_decode",  2'b01, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, DECODE);
    cyc("str_adr",     2'b01, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, MEMADR);
    cyc("str_wait",    2'b01, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, MEMWR);
    cyc("str_wait",    2'b01, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, MEMWR);
    cyc("str_reset",   2'b01, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, FETCH);
    cyc("post_fetch0", 2'b00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, FETCH);
    cyc("post_fetch1", 2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, FETCH);
    cyc("post_decode", 2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, DECODE);
    cyc("post_exec",   2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, EXR);
    cyc("post_wb",     2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, ALUWB);

    // FP op that never completes: FAULT after 15 waits, sticky.
    cyc("to_fetch",  2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, FETCH);
    cyc("to_decode", 2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, DECODE);
    cyc("to_start",  2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, EXF);
    for (int i = 0; i < 15; i++)
      cyc("to_wait", 2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, FPUWAIT);
    cyc("to_fault",        2'b11, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, FAULT);
    cyc("fault_sticky",    2'b11, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, FAULT);
    cyc("fault_sticky",    2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, FAULT);
    cyc("fault_reset",     2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, FETCH);
    cyc("fault_recovered", 2'b00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, FETCH);

    // Drain: every queued expectation must have been checked.
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
